// File: rtl/branch_resolve_pkg.sv
// Shared types and helpers for the branch-resolve block.
// Contents:
//   BP_ADDR_W          instruction-address width used by the slot struct
//   SNT/WNT/WT/ST      2-bit BHT counter states
//   slot_t             one pipeline slot: valid, pc_4, guess_new_pc, guess_state
//   pred_taken()       predicted direction from a BHT state
package bp_pkg;

    localparam int BP_ADDR_W = 10;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic [BP_ADDR_W-1:0] pc_4;
        logic [BP_ADDR_W-1:0] guess_new_pc;
        logic [1:0]           guess_state;
    } slot_t;

    // The upper counter bit alone decides the predicted direction (WT, ST).
    function automatic logic pred_taken(input logic [1:0] state);
        return state[1];
    endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Bundle of every branch_resolve signal except clk/rst.
//   IF side  : if_valid, if_pc_4, if_guess_new_pc, if_guess_state
//   control  : stall
//   EX side  : ex_is_branch, ex_taken, ex_target
//   redirect : redirect_en, redirect_pc, flush
//   BHT write: update_en, update_pc_4, update_pc_remote, update_state_old, branch_succ
//   stats    : branch_cnt, miss_cnt
// master drives the pipeline inputs; slave is the branch_resolve block.
interface branch_resolve_if #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
);
    logic              if_valid;
    logic [ADDR_W-1:0] if_pc_4;
    logic [ADDR_W-1:0] if_guess_new_pc;
    logic [1:0]        if_guess_state;
    logic              stall;
    logic              ex_is_branch;
    logic              ex_taken;
    logic [ADDR_W-1:0] ex_target;
    logic              redirect_en;
    logic [ADDR_W-1:0] redirect_pc;
    logic              flush;
    logic              update_en;
    logic [ADDR_W-1:0] update_pc_4;
    logic [ADDR_W-1:0] update_pc_remote;
    logic [1:0]        update_state_old;
    logic              branch_succ;
    logic [CNT_W-1:0]  branch_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    modport master (
        output if_valid, if_pc_4, if_guess_new_pc, if_guess_state, stall,
               ex_is_branch, ex_taken, ex_target,
        input  redirect_en, redirect_pc, flush, update_en, update_pc_4,
               update_pc_remote, update_state_old, branch_succ, branch_cnt, miss_cnt
    );

    modport slave (
        input  if_valid, if_pc_4, if_guess_new_pc, if_guess_state, stall,
               ex_is_branch, ex_taken, ex_target,
        output redirect_en, redirect_pc, flush, update_en, update_pc_4,
               update_pc_remote, update_state_old, branch_succ, branch_cnt, miss_cnt
    );
endinterface

// File: rtl/branch_resolve_pred_slot.sv
// pred_slot: one prediction-carrying pipeline slot register.
//   clk, rst : clock, async active-high reset
//   clear    : empty the slot (highest priority)
//   load     : capture d (otherwise the slot holds)
//   d / q    : slot contents in / out
module pred_slot
    import bp_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clear,
    input  logic  load,
    input  slot_t d,
    output slot_t q
);

    slot_t slot_r;

    // Slot register: clear beats load beats hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_r <= '0;
        end else if (clear) begin
            slot_r <= '0;
        end else if (load) begin
            slot_r <= d;
        end else begin
            slot_r <= slot_r;
        end
    end

    assign q = slot_r;

endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: carries BHT predictions through ID and EX, resolves them
// against the real outcome at EX, redirects/flushes combinationally on a
// mispredict and emits a registered BHT update one cycle after each branch.
//   clk, rst : clock, async active-high reset
//   bus      : branch_resolve_if.slave (pipeline inputs, redirect, update, stats)
module branch_resolve
    import bp_pkg::*;
#(
    parameter int ADDR_W = BP_ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    branch_resolve_if.slave  bus
);

    slot_t             if_slot_s;
    slot_t             id_slot_s;
    slot_t             ex_slot_s;
    logic [ADDR_W-1:0] pred_next_s;
    logic [ADDR_W-1:0] actual_next_s;
    logic              mispredict_s;
    logic              resolve_s;

    logic              update_en_r;
    logic [ADDR_W-1:0] update_pc_4_r;
    logic [ADDR_W-1:0] update_pc_remote_r;
    logic [1:0]        update_state_old_r;
    logic              branch_succ_r;
    logic [CNT_W-1:0]  branch_cnt_r;
    logic [CNT_W-1:0]  miss_cnt_r;

    // Pack the fetch-stage inputs into a slot.
    always_comb begin
        if_slot_s              = '0;
        if_slot_s.valid        = bus.if_valid;
        if_slot_s.pc_4         = bus.if_pc_4;
        if_slot_s.guess_new_pc = bus.if_guess_new_pc;
        if_slot_s.guess_state  = bus.if_guess_state;
    end

    // ID holds on stall; a flush empties it even when stalled.
    pred_slot u_id (
        .clk   (clk),
        .rst   (rst),
        .clear (mispredict_s),
        .load  (!bus.stall),
        .d     (if_slot_s),
        .q     (id_slot_s)
    );

    // EX takes a bubble on stall or flush, otherwise follows ID.
    pred_slot u_ex (
        .clk   (clk),
        .rst   (rst),
        .clear (mispredict_s | bus.stall),
        .load  (1'b1),
        .d     (id_slot_s),
        .q     (ex_slot_s)
    );

    // Compare predicted and actual next PC of the EX instruction.
    always_comb begin
        pred_next_s   = ex_slot_s.pc_4;
        actual_next_s = ex_slot_s.pc_4;
        if (pred_taken(ex_slot_s.guess_state)) begin
            pred_next_s = ex_slot_s.guess_new_pc;
        end else begin
            pred_next_s = ex_slot_s.pc_4;
        end
        // A non-branch always falls through, whatever ex_taken says.
        if (bus.ex_is_branch && bus.ex_taken) begin
            actual_next_s = bus.ex_target;
        end else begin
            actual_next_s = ex_slot_s.pc_4;
        end
        mispredict_s = ex_slot_s.valid && (pred_next_s != actual_next_s);
        resolve_s    = ex_slot_s.valid && bus.ex_is_branch;
    end

    // Registered BHT update bundle; payload holds between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            update_en_r        <= 1'b0;
            update_pc_4_r      <= '0;
            update_pc_remote_r <= '0;
            update_state_old_r <= 2'b00;
            branch_succ_r      <= 1'b0;
        end else if (resolve_s) begin
            update_en_r        <= 1'b1;
            update_pc_4_r      <= ex_slot_s.pc_4;
            update_pc_remote_r <= bus.ex_target;
            update_state_old_r <= ex_slot_s.guess_state;
            branch_succ_r      <= bus.ex_taken;
        end else begin
            update_en_r        <= 1'b0;
        end
    end

    // Saturating resolve / mispredict counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_r <= '0;
            miss_cnt_r   <= '0;
        end else begin
            if (resolve_s && (branch_cnt_r != {CNT_W{1'b1}})) begin
                branch_cnt_r <= branch_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                branch_cnt_r <= branch_cnt_r;
            end
            if (resolve_s && mispredict_s && (miss_cnt_r != {CNT_W{1'b1}})) begin
                miss_cnt_r <= miss_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                miss_cnt_r <= miss_cnt_r;
            end
        end
    end

    assign bus.redirect_en      = mispredict_s;
    assign bus.flush            = mispredict_s;
    assign bus.redirect_pc      = mispredict_s ? actual_next_s : {ADDR_W{1'b0}};
    assign bus.update_en        = update_en_r;
    assign bus.update_pc_4      = update_pc_4_r;
    assign bus.update_pc_remote = update_pc_remote_r;
    assign bus.update_state_old = update_state_old_r;
    assign bus.branch_succ      = branch_succ_r;
    assign bus.branch_cnt       = branch_cnt_r;
    assign bus.miss_cnt         = miss_cnt_r;

endmodule
